nabp_angle_sequencer: RTL and testbench

Host-side angle sequencer sitting directly upstream of the swap control. It accepts a projection-set command from the host (start angle, step, count). It answers each next-angle request from the swap control with a registered angle and a one-cycle acknowledge, but only when the filtered-projection RAM reports the matching projection ready. It then drains and signals completion once the swap control requests again after the final angle.

---
 rtl/nabp_angle_sequencer_if.sv | 28 ++
 rtl/nabp_angle_sequencer.sv | 138 +++++++++++++
 tb/tb_nabp_angle_sequencer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nabp_angle_sequencer_if.sv
// Swap-control / filtered-RAM handshake bundle for the angle sequencer.
interface nabp_angle_sequencer_if #(
  parameter int unsigned ANGLE_WIDTH = 8
);
  logic                   hs_next_angle;
  logic [ANGLE_WIDTH-1:0] hs_angle;
  logic                   hs_next_angle_ack;
  logic                   fr_proj_valid;
  logic                   fr_proj_consume;

  // Sequencer side
  modport master (
    input  hs_next_angle,
    input  fr_proj_valid,
    output hs_angle,
    output hs_next_angle_ack,
    output fr_proj_consume
  );

  // Swap-control / filtered-RAM side
  modport slave (
    output hs_next_angle,
    output fr_proj_valid,
    input  hs_angle,
    input  hs_next_angle_ack,
    input  fr_proj_consume
  );
endinterface

// File: rtl/nabp_angle_sequencer.sv
// Issues a host-programmed sequence of projection angles to the swap control,
// one per request, gated by filtered-RAM readiness; signals done after drain.
module nabp_angle_sequencer #(
  parameter int unsigned ANGLE_WIDTH = 8,
  parameter int unsigned ANGLE_180   = 180,
  parameter int unsigned COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   host_start,
  input  logic                   host_abort,
  input  logic [ANGLE_WIDTH-1:0] host_angle_init,
  input  logic [ANGLE_WIDTH-1:0] host_angle_step,
  input  logic [COUNT_WIDTH-1:0] host_num_angles,
  output logic                   host_busy,
  output logic                   host_done,
  output logic [COUNT_WIDTH-1:0] host_angles_issued,
  nabp_angle_sequencer_if.master hs
);

  localparam int unsigned SUM_WIDTH = ANGLE_WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    HOLDOFF = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [ANGLE_WIDTH-1:0] step_q, step_d;
  logic [ANGLE_WIDTH-1:0] next_angle_q, next_angle_d;
  logic [ANGLE_WIDTH-1:0] angle_q, angle_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
  logic [COUNT_WIDTH-1:0] issued_q, issued_d;
  logic                   ack_q, ack_d;
  logic                   consume_q, consume_d;
  logic                   busy_q, done_q;

  logic [SUM_WIDTH-1:0]   angle_sum_c;
  logic [ANGLE_WIDTH-1:0] angle_wrapped_c;

  // Next angle modulo 180 degrees
  always_comb begin
    angle_sum_c = SUM_WIDTH'(next_angle_q) + SUM_WIDTH'(step_q);
    if (angle_sum_c >= SUM_WIDTH'(ANGLE_180)) begin
      angle_wrapped_c = ANGLE_WIDTH'(angle_sum_c - SUM_WIDTH'(ANGLE_180));
    end else begin
      angle_wrapped_c = ANGLE_WIDTH'(angle_sum_c);
    end
  end

  // Next-state and datapath update; abort freezes everything but the state
  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    next_angle_d = next_angle_q;
    angle_d      = angle_q;
    remaining_d  = remaining_q;
    issued_d     = issued_q;
    ack_d        = 1'b0;
    consume_d    = 1'b0;

    if (host_abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (host_start) begin
            step_d       = host_angle_step;
            next_angle_d = host_angle_init;
            remaining_d  = host_num_angles;
            issued_d     = '0;
            state_d      = (host_num_angles == '0) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          // The ack cycle itself is spent in ISSUE; the decision to hold off
          // or drain is made there, giving the 3-cycle ack spacing.
          if (ack_q) begin
            state_d = (remaining_q == '0) ? DRAIN : HOLDOFF;
          end else if (hs.hs_next_angle && hs.fr_proj_valid) begin
            ack_d        = 1'b1;
            consume_d    = 1'b1;
            angle_d      = next_angle_q;
            next_angle_d = angle_wrapped_c;
            issued_d     = issued_q + COUNT_WIDTH'(1);
            remaining_d  = remaining_q - COUNT_WIDTH'(1);
          end
        end
        HOLDOFF: state_d = ISSUE;
        DRAIN: begin
          if (hs.hs_next_angle) begin
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      step_q       <= '0;
      next_angle_q <= '0;
      angle_q      <= '0;
      remaining_q  <= '0;
      issued_q     <= '0;
      ack_q        <= 1'b0;
      consume_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      next_angle_q <= next_angle_d;
      angle_q      <= angle_d;
      remaining_q  <= remaining_d;
      issued_q     <= issued_d;
      ack_q        <= ack_d;
      consume_q    <= consume_d;
      busy_q       <= (state_d != IDLE);
      done_q       <= (state_d == DONE);
    end
  end

  assign host_busy            = busy_q;
  assign host_done            = done_q;
  assign host_angles_issued   = issued_q;
  assign hs.hs_angle          = angle_q;
  assign hs.hs_next_angle_ack = ack_q;
  assign hs.fr_proj_consume   = consume_q;

endmodule

// File: tb/tb_nabp_angle_sequencer.sv
// Directed bench for nabp_angle_sequencer: table of angle sets plus
// hand-written stall / zero-count / abort / reset sequences.
module tb_nabp_angle_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       host_start;
  logic       host_abort;
  logic [7:0] host_angle_init;
  logic [7:0] host_angle_step;
  logic [7:0] host_num_angles;
  logic       host_busy;
  logic       host_done;
  logic [7:0] host_angles_issued;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  nabp_angle_sequencer_if #(.ANGLE_WIDTH(8)) bus ();

  nabp_angle_sequencer #(
    .ANGLE_WIDTH(8),
    .ANGLE_180  (180),
    .COUNT_WIDTH(8)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .host_start        (host_start),
    .host_abort        (host_abort),
    .host_angle_init   (host_angle_init),
    .host_angle_step   (host_angle_step),
    .host_num_angles   (host_num_angles),
    .host_busy         (host_busy),
    .host_done         (host_done),
    .host_angles_issued(host_angles_issued),
    .hs                (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]      init;
    logic [7:0]      step;
    logic [7:0]      num;
    logic [3:0][7:0] exp_angle;
    bit              poke;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Wait (bounded) for the next ack; returns 1 if one was seen
  task automatic wait_ack(output bit got);
    got = 1'b0;
    for (int w = 0; w < 8 && !got; w++) begin
      tick();
      if (bus.hs_next_angle_ack) got = 1'b1;
    end
    check("ack_seen", 32'(got), 1);
  endtask

  // Run one angle set with request and valid held high
  task automatic run_set(input vec_t v);
    int last;
    bit got;
    host_angle_init      = v.init;
    host_angle_step      = v.step;
    host_num_angles      = v.num;
    host_start           = 1'b1;
    bus.hs_next_angle    = 1'b1;
    bus.fr_proj_valid    = 1'b1;
    tick();
    host_start = 1'b0;
    check("busy_after_start", 32'(host_busy), 1);
    last = cyc;
    for (int k = 0; k < int'(v.num); k++) begin
      wait_ack(got);
      if (!got) break;
      check("ack_spacing", 32'(cyc - last), (k == 0) ? 1 : 3);
      last = cyc;
      check("angle", 32'(bus.hs_angle), 32'(v.exp_angle[k]));
      check("consume_with_ack", 32'(bus.fr_proj_consume), 1);
      check("issued_count", 32'(host_angles_issued), 32'(k + 1));
      if (v.poke && k == 0) begin
        host_angle_init = 8'd100;
        host_angle_step = 8'd1;
        host_num_angles = 8'd1;
        host_start      = 1'b1;
        tick();
        host_start = 1'b0;
        check("ack_one_cycle", 32'(bus.hs_next_angle_ack), 0);
      end
    end
    tick();
    check("drain_no_done", 32'(host_done), 0);
    check("drain_no_ack", 32'(bus.hs_next_angle_ack), 0);
    tick();
    check("done_pulse", 32'(host_done), 1);
    check("busy_in_done", 32'(host_busy), 1);
    tick();
    check("done_cleared", 32'(host_done), 0);
    check("busy_cleared", 32'(host_busy), 0);
    check("issued_final", 32'(host_angles_issued), 32'(v.num));
    check("angle_retained", 32'(bus.hs_angle), 32'(v.exp_angle[int'(v.num) - 1]));
    bus.hs_next_angle = 1'b0;
    bus.fr_proj_valid = 1'b0;
    tick();
  endtask

  initial begin
    bit got;

    vecs[0] = '{init: 8'd0,   step: 8'd45, num: 8'd4, exp_angle: {8'd135, 8'd90, 8'd45, 8'd0},  poke: 1'b0};
    vecs[1] = '{init: 8'd170, step: 8'd20, num: 8'd3, exp_angle: {8'd0, 8'd30, 8'd10, 8'd170},  poke: 1'b0};
    vecs[2] = '{init: 8'd7,   step: 8'd0,  num: 8'd2, exp_angle: {8'd0, 8'd0, 8'd7, 8'd7},      poke: 1'b0};
    vecs[3] = '{init: 8'd179, step: 8'd1,  num: 8'd2, exp_angle: {8'd0, 8'd0, 8'd0, 8'd179},    poke: 1'b0};
    vecs[4] = '{init: 8'd90,  step: 8'd90, num: 8'd3, exp_angle: {8'd0, 8'd90, 8'd0, 8'd90},    poke: 1'b0};
    vecs[5] = '{init: 8'd0,   step: 8'd60, num: 8'd3, exp_angle: {8'd0, 8'd120, 8'd60, 8'd0},   poke: 1'b1};

    reset_n           = 1'b0;
    host_start        = 1'b0;
    host_abort        = 1'b0;
    host_angle_init   = '0;
    host_angle_step   = '0;
    host_num_angles   = '0;
    bus.hs_next_angle = 1'b0;
    bus.fr_proj_valid = 1'b0;

    // Reset values
    tick();
    tick();
    check("rst_busy", 32'(host_busy), 0);
    check("rst_done", 32'(host_done), 0);
    check("rst_ack", 32'(bus.hs_next_angle_ack), 0);
    check("rst_consume", 32'(bus.fr_proj_consume), 0);
    check("rst_angle", 32'(bus.hs_angle), 0);
    check("rst_issued", 32'(host_angles_issued), 0);
    reset_n = 1'b1;
    tick();

    // Table-driven angle sets
    for (int i = 0; i < 6; i++) run_set(vecs[i]);

    // Starvation stall: request high, valid low for 10 cycles
    host_angle_init   = 8'd10;
    host_angle_step   = 8'd5;
    host_num_angles   = 8'd1;
    host_start        = 1'b1;
    bus.hs_next_angle = 1'b1;
    bus.fr_proj_valid = 1'b0;
    tick();
    host_start = 1'b0;
    check("stall_busy", 32'(host_busy), 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_no_ack", 32'(bus.hs_next_angle_ack), 0);
      check("stall_no_consume", 32'(bus.fr_proj_consume), 0);
    end
    bus.fr_proj_valid = 1'b1;
    tick();
    check("stall_ack", 32'(bus.hs_next_angle_ack), 1);
    check("stall_consume", 32'(bus.fr_proj_consume), 1);
    check("stall_angle", 32'(bus.hs_angle), 10);
    check("stall_issued", 32'(host_angles_issued), 1);
    bus.fr_proj_valid = 1'b0;
    tick();
    check("stall_drain", 32'(host_done), 0);
    tick();
    check("stall_done", 32'(host_done), 1);
    tick();
    check("stall_idle", 32'(host_busy), 0);
    bus.hs_next_angle = 1'b0;
    tick();

    // Zero-count set
    host_angle_init = 8'd5;
    host_angle_step = 8'd5;
    host_num_angles = 8'd0;
    host_start      = 1'b1;
    tick();
    host_start = 1'b0;
    check("zero_done", 32'(host_done), 1);
    check("zero_busy", 32'(host_busy), 1);
    check("zero_ack", 32'(bus.hs_next_angle_ack), 0);
    check("zero_issued", 32'(host_angles_issued), 0);
    tick();
    check("zero_done_clr", 32'(host_done), 0);
    check("zero_busy_clr", 32'(host_busy), 0);
    check("zero_no_ack", 32'(bus.hs_next_angle_ack), 0);

    // Abort after two acks, with a simultaneous start that must be ignored
    host_angle_init   = 8'd0;
    host_angle_step   = 8'd30;
    host_num_angles   = 8'd5;
    host_start        = 1'b1;
    bus.hs_next_angle = 1'b1;
    bus.fr_proj_valid = 1'b1;
    tick();
    host_start = 1'b0;
    wait_ack(got);
    check("abort_angle0", 32'(bus.hs_angle), 0);
    wait_ack(got);
    check("abort_angle1", 32'(bus.hs_angle), 30);
    host_abort      = 1'b1;
    host_start      = 1'b1;
    host_angle_init = 8'd50;
    host_num_angles = 8'd1;
    tick();
    host_abort = 1'b0;
    host_start = 1'b0;
    check("abort_busy", 32'(host_busy), 0);
    check("abort_done", 32'(host_done), 0);
    check("abort_ack", 32'(bus.hs_next_angle_ack), 0);
    check("abort_issued", 32'(host_angles_issued), 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_stays_idle", 32'(host_busy), 0);
      check("abort_no_ack", 32'(bus.hs_next_angle_ack), 0);
      check("abort_no_done", 32'(host_done), 0);
    end
    bus.hs_next_angle = 1'b0;
    bus.fr_proj_valid = 1'b0;
    tick();
    run_set(vecs[1]);

    // Reset in the middle of a set
    host_angle_init   = 8'd0;
    host_angle_step   = 8'd45;
    host_num_angles   = 8'd4;
    host_start        = 1'b1;
    bus.hs_next_angle = 1'b1;
    bus.fr_proj_valid = 1'b1;
    tick();
    host_start = 1'b0;
    wait_ack(got);
    tick();
    reset_n = 1'b0;
    tick();
    check("midrst_busy", 32'(host_busy), 0);
    check("midrst_done", 32'(host_done), 0);
    check("midrst_ack", 32'(bus.hs_next_angle_ack), 0);
    check("midrst_consume", 32'(bus.fr_proj_consume), 0);
    check("midrst_angle", 32'(bus.hs_angle), 0);
    check("midrst_issued", 32'(host_angles_issued), 0);
    reset_n           = 1'b1;
    bus.hs_next_angle = 1'b0;
    bus.fr_proj_valid = 1'b0;
    tick();
    tick();
    check("midrst_no_done", 32'(host_done), 0);
    check("midrst_idle", 32'(host_busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
